bump_recovery_sequencer: RTL and testbench
==========================================

Name: bump_recovery_sequencer

Overview:
- Motion controller for the two-wheel chassis. It sequences the left and right motor drive commands: forward cruise, then an obstacle-recovery sequence when any bumper closes (stop, back up, turn away from the hit side, settle, resume).
- It sits between the board inputs (sysclk, rst, start, bmp[5:0]) and the per-wheel PWM generators / DRV8838 driver pins (duty, DIR, nSLP).
- Timing is derived from the 12 MHz sysclk through an internal millisecond prescaler.

Parameters:
TICK_DIV, 12000, sysclk cycles per 1 ms tick
FWD_DUTY, 8'd128, cruise duty, both wheels
BACK_DUTY, 8'd96, reverse duty, both wheels
TURN_DUTY, 8'd96, spin-turn duty, both wheels
STOP_MS, 100, STOP1/STOP2 settle time in ms
BACK_MS, 500, BACKUP duration in ms
TURN_MS, 400, TURN duration in ms for a single-side hit (a two-side hit uses 2*TURN_MS)

Ports:
sysclk  in  1  system clock, 12 MHz
rst  in  1  asynchronous, active-low reset
start  in  1  start/stop request, asynchronous, rising edge significant
bmp  in  6  bumper switches, active-low, asynchronous; bmp[0] rightmost .. bmp[5] leftmost
duty_l  out  8  left wheel duty command
duty_r  out  8  right wheel duty command
dir_l  out  1  left direction, 0 = forward, 1 = reverse
dir_r  out  1  right direction, 0 = forward, 1 = reverse
nslp_l  out  1  left driver sleep, active-low
nslp_r  out  1  right driver sleep, active-low
state  out  3  current state: IDLE=0, FORWARD=1, STOP1=2, BACKUP=3, TURN=4, STOP2=5
bump_side  out  2  latched hit side: 00 none, 01 right, 10 left, 11 both

Behaviour:
- Reset values (rst low, takes effect immediately, also mid-sequence): state=IDLE, duty_l=duty_r=0, dir_l=dir_r=0, nslp_l=nslp_r=0, bump_side=00, prescaler=0, ms counter=0, synchronizers=all ones. After rst releases, the block stays in IDLE until a start edge.
- start and bmp each pass through a 2-FF synchronizer. A start edge is a synced 0->1 transition. A bump is detected when any synced bmp bit is 0.
- Latency: an input change reaches a state change on the 3rd rising sysclk edge after the input changes (2 synchronizer stages + state register).
- All outputs are registered and update on the same edge as the state register.
- Timed states (STOP1, BACKUP, TURN, STOP2): on entry, the prescaler is cleared to 0 and the ms counter is loaded with the state's duration N.
  - tick = prescaler reaching TICK_DIV-1; the prescaler wraps to 0 on tick.
  - The ms counter decrements on each tick. The state exits on the tick where ms==1.
  - Each timed state therefore lasts exactly N*TICK_DIV cycles.
- Transitions:
  - IDLE: start edge -> FORWARD. Bumps are ignored.
  - FORWARD: start edge -> IDLE (this has priority over a simultaneous bump). Otherwise a bump -> STOP1 and bump_side is latched:
    - any of bmp[2:0] low -> bit0 set;
    - any of bmp[5:3] low -> bit1 set.
  - STOP1 -> BACKUP -> TURN -> STOP2 -> FORWARD on timer expiry.
  - bump_side holds from FORWARD exit until the next FORWARD exit. It is never cleared by re-entering FORWARD.
  - Any running state: start edge -> IDLE immediately. This aborts the timer and the ms counter is zeroed.
  - Bumps outside FORWARD are ignored. If a bump is still asserted on return to FORWARD, STOP1 re-triggers 3 cycles later at most (1 cycle if held).
- TURN direction and duration:
  - bump_side=01 (right hit): turn left, TURN_MS.
  - bump_side=10 (left hit): turn right, TURN_MS.
  - bump_side=11: turn left, 2*TURN_MS.
- Outputs per state:
  - IDLE: duty 0/0, dir 0/0, nslp 0/0.
  - FORWARD: FWD_DUTY on both, dir 0/0, nslp 1/1.
  - STOP1 and STOP2: duty 0/0, dir unchanged from the previous state, nslp 1/1.
  - BACKUP: BACK_DUTY on both, dir 1/1, nslp 1/1.
  - TURN left: TURN_DUTY on both, dir_l=1, dir_r=0. TURN right: TURN_DUTY on both, dir_l=0, dir_r=1. nslp 1/1.
- Width rules: the prescaler and ms counter are sized by $clog2 of TICK_DIV and of 2*max(STOP_MS, BACK_MS, TURN_MS)+1. There is no overflow because loads never exceed these maxima.

Test Plan:
- Bench setup: TICK_DIV=4, STOP_MS=2, BACK_MS=5, TURN_MS=3. Hold rst=0 for 2 cycles, then release.
- Reset and start: check all outputs at reset values. Pulse start for 2 cycles -> state=1, duty_l=duty_r=128, dir=0/0, nslp=1/1, reached 3 edges after the start rise.
- bmp=6'b111110 for 2 cycles in FORWARD -> bump_side=01. Sequence: STOP1 8 cycles (duty 0), BACKUP 20 cycles (96/96, dir 1/1), TURN 12 cycles (dir_l=1, dir_r=0), STOP2 8 cycles, then FORWARD.
- bmp=6'b011111 -> bump_side=10, TURN 12 cycles with dir_l=0, dir_r=1.
- bmp=6'b110011 -> bump_side=11, TURN 24 cycles, turning left.
- Abort and priority:
  - start edge during BACKUP -> IDLE within 3 cycles, duty 0/0, nslp 0/0.
  - start edge and bmp=111110 landing in FORWARD on the same cycle -> IDLE, bump_side unchanged.
- Reset mid-TURN: drive rst=0 asynchronously between clock edges -> outputs go to reset values immediately, without waiting for a clock. Release rst -> stays in IDLE until a start edge.

Source files
------------

// File: rtl/bump_recovery_sequencer.sv
// bump_recovery_sequencer: two-wheel drive sequencer with bumper-triggered stop/back/turn/settle recovery
module bump_recovery_sequencer #(
  parameter int TICK_DIV = 12000,
  parameter logic [7:0] FWD_DUTY = 8'd128,
  parameter logic [7:0] BACK_DUTY = 8'd96,
  parameter logic [7:0] TURN_DUTY = 8'd96,
  parameter int STOP_MS = 100,
  parameter int BACK_MS = 500,
  parameter int TURN_MS = 400
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bmp,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       nslp_l,
  output logic       nslp_r,
  output logic [2:0] state,
  output logic [1:0] bump_side
);
  localparam int MAX_MS = STOP_MS > BACK_MS ? (STOP_MS > TURN_MS ? STOP_MS : TURN_MS)
                                            : (BACK_MS > TURN_MS ? BACK_MS : TURN_MS);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int MW = $clog2(2 * MAX_MS + 1);
  typedef enum logic [2:0] {IDLE, FORWARD, STOP1, BACKUP, TURN, STOP2} st_t;
  st_t st;
  logic [2:0] start_s;
  logic [5:0] bmp_a, bmp_b;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;
  logic start_edge, bump, tick, done, turn_left;
  logic [1:0] side;
  assign start_edge = start_s[1] & ~start_s[2];
  assign bump = ~&bmp_b;
  assign side = {~&bmp_b[5:3], ~&bmp_b[2:0]};
  assign tick = pre == PW'(TICK_DIV - 1);
  assign done = tick && ms == MW'(1);
  assign turn_left = bump_side != 2'b10;
  assign state = st;
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      duty_l <= '0;
      duty_r <= '0;
      dir_l <= 1'b0;
      dir_r <= 1'b0;
      nslp_l <= 1'b0;
      nslp_r <= 1'b0;
      bump_side <= 2'b00;
      pre <= '0;
      ms <= '0;
      start_s <= '1;
      bmp_a <= '1;
      bmp_b <= '1;
    end else begin
      start_s <= {start_s[1:0], start};
      bmp_a <= bmp;
      bmp_b <= bmp_a;
      pre <= tick ? '0 : pre + PW'(1);
      if (tick && ms != '0) ms <= ms - MW'(1);
      if (st != IDLE && start_edge) begin
        st <= IDLE;
        duty_l <= '0;
        duty_r <= '0;
        dir_l <= 1'b0;
        dir_r <= 1'b0;
        nslp_l <= 1'b0;
        nslp_r <= 1'b0;
        pre <= '0;
        ms <= '0;
      end else begin
        case (st)
          IDLE: if (start_edge) begin
            st <= FORWARD;
            duty_l <= FWD_DUTY;
            duty_r <= FWD_DUTY;
            dir_l <= 1'b0;
            dir_r <= 1'b0;
            nslp_l <= 1'b1;
            nslp_r <= 1'b1;
          end
          FORWARD: if (bump) begin
            st <= STOP1;
            bump_side <= side;
            duty_l <= '0;
            duty_r <= '0;
            pre <= '0;
            ms <= MW'(STOP_MS);
          end
          STOP1: if (done) begin
            st <= BACKUP;
            duty_l <= BACK_DUTY;
            duty_r <= BACK_DUTY;
            dir_l <= 1'b1;
            dir_r <= 1'b1;
            pre <= '0;
            ms <= MW'(BACK_MS);
          end
          BACKUP: if (done) begin
            st <= TURN;
            duty_l <= TURN_DUTY;
            duty_r <= TURN_DUTY;
            dir_l <= turn_left;
            dir_r <= ~turn_left;
            pre <= '0;
            ms <= bump_side == 2'b11 ? MW'(2 * TURN_MS) : MW'(TURN_MS);
          end
          TURN: if (done) begin
            st <= STOP2;
            duty_l <= '0;
            duty_r <= '0;
            pre <= '0;
            ms <= MW'(STOP_MS);
          end
          STOP2: if (done) begin
            st <= FORWARD;
            duty_l <= FWD_DUTY;
            duty_r <= FWD_DUTY;
            dir_l <= 1'b0;
            dir_r <= 1'b0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bump_recovery_sequencer.sv
// tb_bump_recovery_sequencer: randomized scoreboard bench against a phase-table model of the recovery sequence
module tb_bump_recovery_sequencer;
  localparam int TD = 4, SMS = 2, BMS = 5, TMS = 3;
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] dl;
    logic [7:0] dr;
    logic il;
    logic ir;
    logic nl;
    logic nr;
    logic [1:0] sd;
  } vec_t;
  logic sysclk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [5:0] bmp = 6'h3f;
  logic [7:0] duty_l, duty_r;
  logic dir_l, dir_r, nslp_l, nslp_r;
  logic [2:0] state;
  logic [1:0] bump_side;
  int cyc = 0, total = 0, passed = 0;
  int exp_c[$];
  vec_t exp_v[$];
  logic [1:0] side_m = 2'b00;
  bump_recovery_sequencer #(.TICK_DIV(TD), .STOP_MS(SMS), .BACK_MS(BMS), .TURN_MS(TMS)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .bmp(bmp),
    .duty_l(duty_l), .duty_r(duty_r), .dir_l(dir_l), .dir_r(dir_r),
    .nslp_l(nslp_l), .nslp_r(nslp_r), .state(state), .bump_side(bump_side)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  function automatic vec_t mk(input int s, input int l, input int r, input bit il, input bit ir,
                              input bit nl, input bit nr, input logic [1:0] sd);
    return {3'(s), 8'(l), 8'(r), il, ir, nl, nr, sd};
  endfunction
  function automatic vec_t cur();
    return {state, duty_l, duty_r, dir_l, dir_r, nslp_l, nslp_r, bump_side};
  endfunction
  function automatic logic [1:0] side_of(input logic [5:0] p);
    return {p[5:3] != 3'b111, p[2:0] != 3'b111};
  endfunction
  task automatic push(input int c, input vec_t v);
    exp_c.push_back(c);
    exp_v.push_back(v);
  endtask
  task automatic check(input string name, input vec_t got, input vec_t want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, want);
  endtask
  initial begin
    vec_t prev, v, e;
    int c;
    prev = mk(0, 0, 0, 0, 0, 0, 0, 2'b00);
    forever begin
      @(negedge sysclk);
      v = cur();
      if (v !== prev) begin
        total++;
        if (exp_c.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d got %h was %h", cyc, v, prev);
        end else begin
          c = exp_c.pop_front();
          e = exp_v.pop_front();
          if (v === e && cyc == c) passed++;
          else $display("FAIL transition cyc=%0d got %h want %h at cyc %0d", cyc, v, e, c);
        end
        prev = v;
      end
    end
  end
  task automatic model_bump(input int k, input logic [5:0] p, input int cut, output int fin);
    logic [1:0] sd;
    bit lt;
    int c[5];
    vec_t v[5];
    sd = side_of(p);
    lt = sd != 2'b10;
    c[0] = k + 3;
    c[1] = c[0] + TD * SMS;
    c[2] = c[1] + TD * BMS;
    c[3] = c[2] + TD * TMS * (sd == 2'b11 ? 2 : 1);
    c[4] = c[3] + TD * SMS;
    v[0] = mk(2, 0, 0, 0, 0, 1, 1, sd);
    v[1] = mk(3, 96, 96, 1, 1, 1, 1, sd);
    v[2] = mk(4, 96, 96, lt, !lt, 1, 1, sd);
    v[3] = mk(5, 0, 0, lt, !lt, 1, 1, sd);
    v[4] = mk(1, 128, 128, 0, 0, 1, 1, sd);
    for (int i = 0; i < 5; i++) if (c[i] < cut) push(c[i], v[i]);
    side_m = sd;
    fin = c[4];
  endtask
  task automatic pulse_start(input bit fwd);
    int k;
    @(negedge sysclk);
    k = cyc;
    push(k + 3, fwd ? mk(1, 128, 128, 0, 0, 1, 1, side_m) : mk(0, 0, 0, 0, 0, 0, 0, side_m));
    start = 1'b1;
    repeat (2) @(negedge sysclk);
    start = 1'b0;
    while (cyc < k + 6) @(negedge sysclk);
  endtask
  task automatic run_bump(input logic [5:0] p, input int h, input int a);
    int k, cut, fin, ab, span;
    @(negedge sysclk);
    k = cyc;
    span = TD * (2 * SMS + BMS + TMS * (side_of(p) == 2'b11 ? 2 : 1));
    ab = a < 0 ? int'($urandom_range(1, span - 1)) : a;
    cut = ab > 0 ? k + ab + 3 : k + 100000;
    model_bump(k, p, cut, fin);
    if (ab > 0) push(cut, mk(0, 0, 0, 0, 0, 0, 0, side_m));
    for (int i = 0; i < h || (ab > 0 && i < ab + 2); i++) begin
      bmp = i < h ? p : 6'h3f;
      start = ab > 0 && i >= ab && i < ab + 2;
      @(negedge sysclk);
    end
    bmp = 6'h3f;
    start = 1'b0;
    while (cyc < (ab > 0 ? cut : fin) + 2) @(negedge sysclk);
    if (ab > 0) pulse_start(1'b1);
  endtask
  initial begin
    int k, c, fin;
    #1 rst = 1'b0;
    repeat (2) @(negedge sysclk);
    check("reset", cur(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
    rst = 1'b1;
    pulse_start(1'b1);
    run_bump(6'b111110, 2, 0);
    run_bump(6'b011111, 2, 0);
    run_bump(6'b110011, 2, 0);
    @(negedge sysclk);
    k = cyc;
    push(k + 3, mk(0, 0, 0, 0, 0, 0, 0, side_m));
    start = 1'b1;
    bmp = 6'b111110;
    repeat (2) @(negedge sysclk);
    start = 1'b0;
    bmp = 6'h3f;
    while (cyc < k + 8) @(negedge sysclk);
    pulse_start(1'b1);
    run_bump(6'b011111, 2, 10);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge sysclk);
      run_bump(6'($urandom_range(0, 62)), int'($urandom_range(1, 3)), $urandom_range(0, 1) != 0 ? -1 : 0);
    end
    @(negedge sysclk);
    k = cyc;
    c = k + 3 + TD * (SMS + BMS) + 5;
    model_bump(k, 6'b111110, c, fin);
    bmp = 6'b111110;
    repeat (2) @(negedge sysclk);
    bmp = 6'h3f;
    while (cyc < c - 1) @(negedge sysclk);
    side_m = 2'b00;
    push(c, mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
    @(posedge sysclk);
    #2 rst = 1'b0;
    #1 check("async_reset", cur(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
    repeat (2) @(negedge sysclk);
    rst = 1'b1;
    repeat (10) @(negedge sysclk);
    check("idle_hold", cur(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00));
    pulse_start(1'b1);
    run_bump(6'($urandom_range(0, 62)), 2, 0);
    repeat (20) @(negedge sysclk);
    total++;
    if (exp_c.size() == 0) passed++;
    else $display("FAIL queue_drain got %0d pending want 0", exp_c.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
